// File: rtl/ram_access_arbiter.sv
// Round-robin sharing of one external single-port synchronous RAM between two
// req/ack requesters, plus a sequencer that fills the whole RAM with a constant.
module ram_access_arbiter #(
  parameter int               width          = 16,
  parameter int               widthad        = 10,
  parameter logic [width-1:0] CLEAR_VALUE    = '0,
  parameter bit               CLEAR_ON_RESET = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_start,
  output logic               busy,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [widthad-1:0] a_addr,
  input  logic [width-1:0]   a_wdata,
  output logic               a_ack,
  output logic [width-1:0]   a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [widthad-1:0] b_addr,
  input  logic [width-1:0]   b_wdata,
  output logic               b_ack,
  output logic [width-1:0]   b_rdata,
  output logic               ram_wren,
  output logic [widthad-1:0] ram_address,
  output logic [width-1:0]   ram_data,
  input  logic [width-1:0]   ram_q
);

  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, RESP} state_t;

  localparam logic [widthad:0] last_count = {1'b0, {widthad{1'b1}}};

  state_t               state, state_n;
  logic [widthad:0]     count, count_n;
  logic                 pend, pend_n;
  logic                 last_b, last_b_n;   // winner of the most recent tie
  logic                 sel_b, sel_b_n;     // requester owning the in-flight access
  logic                 busy_n;
  logic                 a_ack_n, b_ack_n;
  logic [width-1:0]     a_rdata_n, b_rdata_n;
  logic                 ram_wren_n;
  logic [widthad-1:0]   ram_address_n;
  logic [width-1:0]     ram_data_n;
  logic                 a_elig, b_elig, pick_b;

  // A requester whose ack is high this cycle is finishing, not asking again.
  assign a_elig = a_req & ~a_ack;
  assign b_elig = b_req & ~b_ack;
  assign pick_b = b_elig & (~a_elig | ~last_b);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_n       = state;
    count_n       = count;
    pend_n        = pend;
    last_b_n      = last_b;
    sel_b_n       = sel_b;
    a_ack_n       = 1'b0;
    b_ack_n       = 1'b0;
    a_rdata_n     = a_rdata;
    b_rdata_n     = b_rdata;
    ram_wren_n    = ram_wren;
    ram_address_n = ram_address;
    ram_data_n    = ram_data;

    case (state)
      CLEAR: begin
        ram_wren_n    = 1'b1;
        ram_address_n = count[widthad-1:0];
        ram_data_n    = CLEAR_VALUE;
        count_n       = count + 1'b1;
        if (count == last_count) state_n = IDLE;
      end
      IDLE: begin
        ram_wren_n = 1'b0;
        if (pend || clear_start) begin
          state_n = CLEAR;
          count_n = '0;
          pend_n  = 1'b0;
        end else if (!busy && (a_elig || b_elig)) begin
          sel_b_n = pick_b;
          if (a_elig && b_elig) last_b_n = pick_b;
          ram_wren_n    = pick_b ? b_we    : a_we;
          ram_address_n = pick_b ? b_addr  : a_addr;
          ram_data_n    = pick_b ? b_wdata : a_wdata;
          state_n       = ACCESS;
        end
      end
      ACCESS: begin
        ram_wren_n = 1'b0;
        pend_n     = pend | clear_start;
        state_n    = RESP;
      end
      RESP: begin
        pend_n = pend | clear_start;
        if (sel_b) begin
          b_ack_n   = 1'b1;
          b_rdata_n = ram_q;
        end else begin
          a_ack_n   = 1'b1;
          a_rdata_n = ram_q;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Held through the IDLE cycle after the last clear write so busy and
    // ram_wren fall on the same edge.
    busy_n = (state == CLEAR) || (state_n == CLEAR) || pend_n;
  end

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= CLEAR_ON_RESET ? CLEAR : IDLE;
      count       <= '0;
      pend        <= 1'b0;
      last_b      <= 1'b1;
      sel_b       <= 1'b0;
      busy        <= CLEAR_ON_RESET;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      pend        <= pend_n;
      last_b      <= last_b_n;
      sel_b       <= sel_b_n;
      busy        <= busy_n;
      a_ack       <= a_ack_n;
      b_ack       <= b_ack_n;
      a_rdata     <= a_rdata_n;
      b_rdata     <= b_rdata_n;
      ram_wren    <= ram_wren_n;
      ram_address <= ram_address_n;
      ram_data    <= ram_data_n;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: behavioural RAM, shadow-memory reference,
// directed timing steps followed by two concurrent random requesters.
module tb_ram_access_arbiter;

  localparam logic [15:0] CV = 16'h00FF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear_start = 1'b0;
  logic        busy;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [3:0]  a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [3:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        ram_wren;
  logic [3:0]  ram_address;
  logic [15:0] ram_data;
  logic [15:0] ram_q;

  logic [15:0] mem [16] = '{default: 16'hDEAD};
  logic [15:0] shadow [16];

  int total = 0;
  int bad = 0;
  int collide = 0;
  int b_acks = 0;

  ram_access_arbiter #(
    .width(16), .widthad(4), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .clear_start(clear_start), .busy(busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM: registered read, write-through q.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= ram_wren ? ram_data : mem[ram_address];
  end

  always @(negedge clock) begin
    if (a_ack === 1'b1 && b_ack === 1'b1) collide++;
    if (b_ack === 1'b1) b_acks++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction; called at a negedge, returns at the ack negedge.
  task automatic xact(input bit side, input bit we, input logic [3:0] addr,
                      input logic [15:0] wd, output int lat, output logic [15:0] rd);
    bit got = 1'b0;
    lat = 0;
    rd  = 'x;
    if (side) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    else      begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      got = side ? (b_ack === 1'b1) : (a_ack === 1'b1);
      if (got) rd = side ? b_rdata : a_rdata;
    end
    if (side) b_req = 1'b0; else a_req = 1'b0;
    check(side ? "b_ack_timeout" : "a_ack_timeout", 32'(got), 32'(1));
  endtask

  task automatic rand_agent(input bit side, input int n);
    int lat;
    logic [15:0] rd, wd, expd;
    logic [3:0] ad;
    bit we;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      we = 1'($urandom_range(0, 1));
      ad = 4'($urandom_range(0, 15));
      wd = 16'($urandom);
      xact(side, we, ad, wd, lat, rd);
      expd = we ? wd : shadow[ad];
      if (we) shadow[ad] = wd;
      check(side ? "rnd_b_data" : "rnd_a_data", 32'(rd), 32'(expd));
      check(side ? "rnd_b_lat" : "rnd_a_lat", 32'(lat <= 6), 32'(1));
    end
  endtask

  initial begin
    int lat;
    int b0;
    logic [15:0] rd;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_a_ack", 32'(a_ack), 0);
    check("rst_b_ack", 32'(b_ack), 0);
    check("rst_a_rdata", 32'(a_rdata), 0);
    check("rst_b_rdata", 32'(b_rdata), 0);
    check("rst_wren", 32'(ram_wren), 0);
    check("rst_addr", 32'(ram_address), 0);
    check("rst_data", 32'(ram_data), 0);
    check("rst_busy", 32'(busy), 1);

    // Clear after reset: 16 consecutive writes of CV
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check("clr_wren", 32'(ram_wren), 1);
      check("clr_addr", 32'(ram_address), 32'(i));
      check("clr_data", 32'(ram_data), 32'(CV));
      check("clr_busy", 32'(busy), 1);
    end
    @(negedge clock);
    check("clr_end_wren", 32'(ram_wren), 0);
    check("clr_end_busy", 32'(busy), 0);
    xact(0, 0, 4'd3, 16'h0, lat, rd);
    check("post_clr_rd", 32'(rd), 32'(CV));
    check("post_clr_lat", 32'(lat), 3);
    @(negedge clock);

    // Single A write then read
    b0 = b_acks;
    xact(0, 1, 4'd5, 16'h1234, lat, rd);
    check("a_wr_lat", 32'(lat), 3);
    check("a_wr_rdata", 32'(rd), 32'h1234);
    check("a_wr_mem", 32'(mem[5]), 32'h1234);
    @(negedge clock);
    xact(0, 0, 4'd5, 16'h0, lat, rd);
    check("a_rd_lat", 32'(lat), 3);
    check("a_rd_data", 32'(rd), 32'h1234);
    @(negedge clock);
    check("a_ack_pulse", 32'(a_ack), 0);
    check("a_rdata_hold", 32'(a_rdata), 32'h1234);
    check("b_quiet", 32'(b_acks), 32'(b0));

    // Tie fairness: both held continuously
    xact(1, 1, 4'd1, 16'h1111, lat, rd);
    check("b_wr_lat", 32'(lat), 3);
    @(negedge clock);
    xact(0, 1, 4'd2, 16'h2222, lat, rd);
    @(negedge clock);
    a_we = 1'b0; a_addr = 4'd1; a_req = 1'b1;
    b_we = 1'b0; b_addr = 4'd2; b_req = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clock);
      check("tie_a_ack", 32'(a_ack), 32'(k % 6 == 3));
      check("tie_b_ack", 32'(b_ack), 32'(k % 6 == 0));
      if (k % 6 == 3) check("tie_a_rdata", 32'(a_rdata), 32'h1111);
      if (k % 6 == 0) check("tie_b_rdata", 32'(b_rdata), 32'h2222);
      if (k == 15) a_req = 1'b0;
      if (k == 18) b_req = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("tie_tail_ack", 32'({a_ack, b_ack}), 0);
    end

    // Ack-cycle guard: A holds req through its ack, B asks in that ack cycle
    a_we = 1'b0; a_addr = 4'd2; a_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      check("grd_a_ack", 32'(a_ack), 32'(k == 3 || k == 9));
      check("grd_b_ack", 32'(b_ack), 32'(k == 6));
      if (k == 3 || k == 9) check("grd_a_rdata", 32'(a_rdata), 32'h2222);
      if (k == 6) check("grd_b_rdata", 32'(b_rdata), 32'h1111);
      if (k == 3) begin b_we = 1'b0; b_addr = 4'd1; b_req = 1'b1; end
      if (k == 6) b_req = 1'b0;
      if (k == 9) a_req = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("grd_tail_ack", 32'({a_ack, b_ack}), 0);
    end

    // clear_start during an A write; B read queued behind the clear
    a_we = 1'b1; a_addr = 4'd7; a_wdata = 16'hABCD; a_req = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clock);
      check("cs_a_ack", 32'(a_ack), 32'(k == 3));
      check("cs_b_ack", 32'(b_ack), 32'(k == 24));
      check("cs_busy", 32'(busy), 32'(k >= 2 && k <= 20));
      check("cs_wren", 32'(ram_wren), 32'(k == 1 || (k >= 5 && k <= 20)));
      if (k >= 5 && k <= 20) check("cs_addr", 32'(ram_address), 32'(k - 5));
      if (k == 3) check("cs_a_rdata", 32'(a_rdata), 32'hABCD);
      if (k == 24) check("cs_b_rdata", 32'(b_rdata), 32'(CV));
      if (k == 1) clear_start = 1'b1;
      if (k == 2) clear_start = 1'b0;
      if (k == 3) a_req = 1'b0;
      if (k == 4) begin b_we = 1'b0; b_addr = 4'd7; b_req = 1'b1; end
      if (k == 24) b_req = 1'b0;
    end
    @(negedge clock);

    // Reset while the clear counter is 7: clear restarts from address 0
    clear_start = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clock);
      if (k == 1) clear_start = 1'b0;
      check("mid_ack", 32'({a_ack, b_ack}), 0);
      check("mid_busy", 32'(busy), 32'(k <= 26));
      if (k >= 2 && k <= 8) check("mid_addr_pre", 32'(ram_address), 32'(k - 2));
      if (k == 10) begin
        check("mid_rst_wren", 32'(ram_wren), 0);
        check("mid_rst_addr", 32'(ram_address), 0);
        check("mid_rst_rdata", 32'({a_rdata, b_rdata}), 0);
      end
      if (k >= 11 && k <= 26) begin
        check("mid_addr_post", 32'(ram_address), 32'(k - 11));
        check("mid_data_post", 32'(ram_data), 32'(CV));
      end
      check("mid_wren", 32'(ram_wren), 32'((k >= 2 && k <= 8) || (k >= 11 && k <= 26)));
      if (k == 8) reset = 1'b1;
      if (k == 10) reset = 1'b0;
    end

    // Random traffic from both requesters against the shadow memory
    for (int i = 0; i < 16; i++) shadow[i] = CV;
    fork
      rand_agent(1'b0, 30);
      rand_agent(1'b1, 30);
    join
    check("ack_collisions", 32'(collide), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares one synchronous single-port RAM between two requesters, A and B, using round-robin arbitration and a req/ack handshake.
- Contains a clear sequencer that fills the whole RAM with a constant after reset and on command.
- The RAM has 1-cycle registered read latency and write-through q. Typical use: sharing palette/sprite work RAM between CPU and a video DMA.
- The RAM instance is external; this block drives its port.

Parameters:
- width, 16, RAM data width
- widthad, 10, RAM address width; depth is 2**widthad
- CLEAR_VALUE, 0, word written by the clear sequencer (width bits)
- CLEAR_ON_RESET, 1, 1 = clear starts automatically when reset deasserts

Ports:
- clock  in  1  the only clock.
- reset  in  1  synchronous, active-high.
- clear_start  in  1  single-cycle pulse that requests a full clear.
- busy  out  1  high while a clear is pending or running.
- a_req  in  1  requester A access request. a_we, a_addr and a_wdata must be held stable while it is high.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  widthad  requester A address.
- a_wdata  in  width  requester A write data.
- a_ack  out  1  1-cycle completion pulse for requester A.
- a_rdata  out  width  read data, valid while a_ack is high; holds its value otherwise.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the A signals, for requester B.
- ram_wren  out  1  RAM write enable (registered).
- ram_address  out  widthad  RAM address (registered).
- ram_data  out  width  RAM write data (registered).
- ram_q  in  width  RAM read data, valid 1 cycle after the address is presented.

Behaviour:
- Reset values:
  - a_ack = b_ack = 0, a_rdata = b_rdata = 0.
  - ram_wren = 0, ram_address = 0, ram_data = 0.
  - busy = CLEAR_ON_RESET.
  - Round-robin pointer set to "B last granted", so A wins the first tie.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE. Clear counter = 0.
- Reset asserted mid-operation: the in-flight access is abandoned with no ack. A clear restarts from address 0 if CLEAR_ON_RESET.
- States: CLEAR, IDLE, ACCESS, RESP.
- CLEAR:
  - Each cycle registers ram_wren=1, ram_address=counter, ram_data=CLEAR_VALUE, then increments the counter.
  - Addresses 0..2**widthad-1 are written on consecutive cycles, one per cycle.
  - After issuing the last address: go to IDLE, ram_wren returns to 0 at the next edge, busy falls at the same edge as ram_wren.
  - No requests are granted while busy is high.
- IDLE:
  - Eligible requester = req high AND its ack not high this cycle; an ack cycle never re-grants the same transaction.
  - If a clear is pending, go to CLEAR with counter = 0. The clear has priority over requesters.
  - If only one requester is eligible, grant it. If both are, grant the one not granted last and update the pointer.
  - On a grant: register ram_address=addr, ram_wren=we, ram_data=wdata, then go to ACCESS.
  - If nothing is eligible, ram_wren = 0.
- ACCESS: ram_wren cleared at the next edge; go to RESP.
- RESP:
  - Capture ram_q into the granted requester's rdata (also for writes; it then equals the written data).
  - Pulse that requester's ack for exactly one cycle; go to IDLE.
- Timing:
  - Request sampled in IDLE at cycle T → RAM port valid cycle T+1 → ack high cycle T+3.
  - Peak throughput is one access per 3 cycles.
- Requesters may drop req in the ack cycle. A req still held after the ack cycle is treated as a new transaction.
- Dropping req before ack is illegal and the behaviour is unspecified.
- clear_start:
  - While in IDLE: busy rises the next cycle.
  - During ACCESS/RESP: latched; busy rises the next cycle, and the clear starts after the current transaction acks.
  - While already in CLEAR: ignored; the counter does not restart.
- Address arithmetic: the clear counter is widthad+1 bits and terminates at 2**widthad. Requester addresses pass through unmodified.

Test Plan:
- Reset clear, widthad=4, CLEAR_VALUE=16'h00FF: release reset → 16 consecutive writes on ram_address 0..15, data 00FF. busy falls with ram_wren, then any read returns 00FF.
- Single A write/read, post-clear: A writes addr 5 = 16'h1234 with req at cycle T → a_ack at T+3. A then reads addr 5 → a_rdata = 1234 with a_ack. b_ack stays 0 throughout.
- Tie fairness: a_req and b_req held continuously, reading addrs 1 and 2 → grants alternate A, B, A, B. Acks are 3 cycles apart and never coincide.
- Ack-cycle guard: A holds req through its ack for 1 cycle → exactly two acks, not three. B's request raised in A's ack cycle is granted the next IDLE.
- clear_start during an A write: the A write acks normally, then busy stays high for the full clear. A read issued during the clear acks only after busy falls and returns CLEAR_VALUE.
- Reset mid-clear at counter=7: no ack is pulsed, and the clear restarts at address 0.
